// File: rtl/unfilter_pkg.sv
// Shared sizing/filter-code defines and the per-lane reconstruction helpers.
`ifndef UNFILTER_DEFINES
`define UNFILTER_DEFINES
`define SIZE_W_MAX  16
`define SIZE_W_WD   5
`define SIZE_H_WD   8
`define DATA_PXL_WD 24
`define FILT_NONE   3'd0
`define FILT_SUB    3'd1
`define FILT_UP     3'd2
`define FILT_AVG    3'd3
`define FILT_PAETH  3'd4
`endif

package unfilter_pkg;

   localparam int unsigned SIZE_W_WD = `SIZE_W_WD;
   localparam int unsigned SIZE_H_WD = `SIZE_H_WD;

   localparam logic [2:0] FILT_NONE  = `FILT_NONE;
   localparam logic [2:0] FILT_SUB   = `FILT_SUB;
   localparam logic [2:0] FILT_UP    = `FILT_UP;
   localparam logic [2:0] FILT_AVG   = `FILT_AVG;
   localparam logic [2:0] FILT_PAETH = `FILT_PAETH;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_TYPE = 2'd1;
   localparam logic [1:0] ST_PIX  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   function automatic logic [7:0] paeth_pred(input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] c);
      logic signed [9:0] sa, sb, sc, p, pa, pb, pc;
      sa = $signed({2'b00, a});
      sb = $signed({2'b00, b});
      sc = $signed({2'b00, c});
      p  = sa + sb - sc;
      pa = (p >= sa) ? p - sa : sa - p;
      pb = (p >= sb) ? p - sb : sb - p;
      pc = (p >= sc) ? p - sc : sc - p;
      if ((pa <= pb) && (pa <= pc)) return a;
      else if (pb <= pc)            return b;
      else                          return c;
   endfunction

   function automatic logic [7:0] recon_lane(input logic [2:0] typ, input logic [7:0] x,
                                             input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] c);
      logic [8:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      case (typ)
         FILT_SUB:   return x + a;
         FILT_UP:    return x + b;
         FILT_AVG:   return x + sum[8:1];
         FILT_PAETH: return x + paeth_pred(a, b, c);
         default:    return x;
      endcase
   endfunction

endpackage

// File: rtl/unfilter_if.sv
// Image stream and control signals between a pixel source and the unfilter.
interface unfilter_if #(
   parameter int unsigned SIZE_W_WD   = `SIZE_W_WD,
   parameter int unsigned SIZE_H_WD   = `SIZE_H_WD,
   parameter int unsigned DATA_PXL_WD = `DATA_PXL_WD
);
   logic [SIZE_W_WD-1:0]   cfg_w_i;
   logic [SIZE_H_WD-1:0]   cfg_h_i;
   logic                   start_i;
   logic                   done_o;
   logic                   val_i;
   logic [DATA_PXL_WD-1:0] dat_i;
   logic                   val_o;
   logic [DATA_PXL_WD-1:0] dat_o;
   logic                   err_o;

   modport master (
      output cfg_w_i, cfg_h_i, start_i, val_i, dat_i,
      input  done_o, val_o, dat_o, err_o
   );

   modport slave (
      input  cfg_w_i, cfg_h_i, start_i, val_i, dat_i,
      output done_o, val_o, dat_o, err_o
   );
endinterface

// File: rtl/unfilter_linebuf.sv
// One-row line buffer: single write port, single read port with registered read.
module unfilter_linebuf #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 24,
   parameter int unsigned AW    = 4
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/unfilter.sv
// PNG-style row unfilter: type beat per row, then pixels reconstructed per byte lane
// through a two-stage pipeline using a line buffer holding the previous row.
module unfilter
   import unfilter_pkg::*;
#(
   parameter int unsigned SIZE_W_MAX  = `SIZE_W_MAX,
   parameter int unsigned DATA_PXL_WD = `DATA_PXL_WD
) (
   input logic       clk,
   input logic       rstn,
   unfilter_if.slave bus
);
   localparam int unsigned AW = (SIZE_W_MAX > 1) ? $clog2(SIZE_W_MAX) : 1;
   localparam int unsigned NL = DATA_PXL_WD / 8;

   logic [1:0]             state_q, state_d;
   logic [SIZE_W_WD-1:0]   col_q, col_d, cfg_w_q, cfg_w_d;
   logic [SIZE_H_WD-1:0]   row_q, row_d, cfg_h_q, cfg_h_d;
   logic [2:0]             type_q, type_d;
   logic                   err_q, err_d, done_q, done_d;
   logic                   pix_beat, last_col, last_row, type_bad;

   logic                   s1_val_q, s1_val_d, s1_col0_q, s1_col0_d, s1_row0_q, s1_row0_d;
   logic                   s1_fwd_q, s1_fwd_d;
   logic [2:0]             s1_type_q, s1_type_d;
   logic [AW-1:0]          s1_col_q, s1_col_d, out_col_q, out_col_d;
   logic [DATA_PXL_WD-1:0] s1_x_q, s1_x_d, s1_fwd_dat_q, s1_fwd_dat_d;
   logic [DATA_PXL_WD-1:0] c_q, c_d, dat_q, dat_d, rd_dat, a_px, b_px, c_px, recon;
   logic                   val_q, val_d;

   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      row_d    = row_q;
      cfg_w_d  = cfg_w_q;
      cfg_h_d  = cfg_h_q;
      type_d   = type_q;
      err_d    = err_q;
      done_d   = 1'b0;
      pix_beat = (state_q == ST_PIX) && bus.val_i;
      last_col = (col_q == cfg_w_q - 1'b1);
      last_row = (row_q == cfg_h_q - 1'b1);
      type_bad = (bus.dat_i[7:3] != 5'd0) || (bus.dat_i[2:0] > FILT_PAETH);
      case (state_q)
         ST_IDLE: begin
            if (bus.start_i) begin
               cfg_w_d = bus.cfg_w_i;
               cfg_h_d = bus.cfg_h_i;
               err_d   = 1'b0;
               row_d   = '0;
               col_d   = '0;
               state_d = ST_TYPE;
            end
         end
         ST_TYPE: begin
            if (bus.val_i) begin
               type_d  = type_bad ? FILT_NONE : bus.dat_i[2:0];
               err_d   = err_q | type_bad;
               col_d   = '0;
               state_d = ST_PIX;
            end
         end
         ST_PIX: begin
            if (bus.val_i) begin
               if (last_col) begin
                  col_d = '0;
                  if (last_row) begin
                     state_d = ST_DONE;
                  end else begin
                     row_d   = row_q + 1'b1;
                     state_d = ST_TYPE;
                  end
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         default: begin
            // Last pixel is in the output stage and nothing remains behind it.
            if (val_q && !s1_val_q) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   // Stage 0: capture the pixel and issue the above-row read for its column.
   always_comb begin
      s1_val_d     = pix_beat;
      s1_x_d       = bus.dat_i;
      s1_type_d    = type_q;
      s1_col_d     = col_q[AW-1:0];
      s1_col0_d    = (col_q == '0);
      s1_row0_d    = (row_q == '0);
      s1_fwd_d     = pix_beat && val_q && (out_col_q == col_q[AW-1:0]);
      s1_fwd_dat_d = dat_q;
   end

   unfilter_linebuf #(
      .DEPTH (SIZE_W_MAX),
      .WIDTH (DATA_PXL_WD),
      .AW    (AW)
   ) u_linebuf (
      .clk_i   (clk),
      .we_i    (val_q),
      .waddr_i (out_col_q),
      .wdata_i (dat_q),
      .raddr_i (col_q[AW-1:0]),
      .rdata_o (rd_dat)
   );

   // Stage 1: neighbours and reconstruction; dat_q always holds the left pixel.
   always_comb begin
      a_px  = s1_col0_q ? '0 : dat_q;
      b_px  = s1_row0_q ? '0 : (s1_fwd_q ? s1_fwd_dat_q : rd_dat);
      c_px  = (s1_row0_q || s1_col0_q) ? '0 : c_q;
      recon = '0;
      for (int l = 0; l < NL; l++) begin
         recon[8*l +: 8] = recon_lane(s1_type_q, s1_x_q[8*l +: 8], a_px[8*l +: 8],
                                      b_px[8*l +: 8], c_px[8*l +: 8]);
      end
      val_d     = s1_val_q;
      dat_d     = s1_val_q ? recon : dat_q;
      out_col_d = s1_val_q ? s1_col_q : out_col_q;
      c_d       = s1_val_q ? b_px : c_q;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q      <= ST_IDLE;
         col_q        <= '0;
         row_q        <= '0;
         cfg_w_q      <= '0;
         cfg_h_q      <= '0;
         type_q       <= FILT_NONE;
         err_q        <= 1'b0;
         done_q       <= 1'b0;
         s1_val_q     <= 1'b0;
         s1_x_q       <= '0;
         s1_type_q    <= FILT_NONE;
         s1_col_q     <= '0;
         s1_col0_q    <= 1'b0;
         s1_row0_q    <= 1'b0;
         s1_fwd_q     <= 1'b0;
         s1_fwd_dat_q <= '0;
         c_q          <= '0;
         val_q        <= 1'b0;
         dat_q        <= '0;
         out_col_q    <= '0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         cfg_w_q      <= cfg_w_d;
         cfg_h_q      <= cfg_h_d;
         type_q       <= type_d;
         err_q        <= err_d;
         done_q       <= done_d;
         s1_val_q     <= s1_val_d;
         s1_x_q       <= s1_x_d;
         s1_type_q    <= s1_type_d;
         s1_col_q     <= s1_col_d;
         s1_col0_q    <= s1_col0_d;
         s1_row0_q    <= s1_row0_d;
         s1_fwd_q     <= s1_fwd_d;
         s1_fwd_dat_q <= s1_fwd_dat_d;
         c_q          <= c_d;
         val_q        <= val_d;
         dat_q        <= dat_d;
         out_col_q    <= out_col_d;
      end
   end

   assign bus.val_o  = val_q;
   assign bus.dat_o  = dat_q;
   assign bus.done_o = done_q;
   assign bus.err_o  = err_q;
endmodule

// File: tb/tb_unfilter.sv
// Directed bench for unfilter: image-level reference model plus per-cycle output compare.
module tb_unfilter;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   unfilter_if #(.SIZE_W_WD(5), .SIZE_H_WD(8), .DATA_PXL_WD(24)) bus_if ();

   unfilter #(.SIZE_W_MAX(16), .DATA_PXL_WD(24)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus_if)
   );

   typedef struct {
      int          due;
      logic [23:0] mdl;
      logic [23:0] lit;
      bit          has_lit;
   } exp_t;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          done_due = -1;
   bit          chk_en = 1'b0;
   exp_t        exp_q[$];
   logic [7:0]  typ_in[4];
   logic [23:0] pix_in[16];
   logic [23:0] lit_in[16];
   logic [23:0] rec[16];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference reconstruction of the whole image from the filter definitions.
   task automatic compute_model(input int w, input int h);
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            int i = r * w + c;
            for (int l = 0; l < 3; l++) begin
               int x, a, b, cc, p, pa, pb, pc, pr, t;
               x  = int'(pix_in[i][8*l +: 8]);
               a  = (c > 0) ? int'(rec[i-1][8*l +: 8]) : 0;
               b  = (r > 0) ? int'(rec[i-w][8*l +: 8]) : 0;
               cc = (r > 0 && c > 0) ? int'(rec[i-w-1][8*l +: 8]) : 0;
               t  = int'(typ_in[r]);
               if (t > 4) t = 0;
               p  = a + b - cc;
               pa = (p > a) ? p - a : a - p;
               pb = (p > b) ? p - b : b - p;
               pc = (p > cc) ? p - cc : cc - p;
               case (t)
                  1: pr = a;
                  2: pr = b;
                  3: pr = (a + b) / 2;
                  4: pr = (pa <= pb && pa <= pc) ? a : ((pb <= pc) ? b : cc);
                  default: pr = 0;
               endcase
               rec[i][8*l +: 8] = 8'((x + pr) % 256);
            end
         end
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            check("val_o", 32'(bus_if.val_o), 32'd1);
            check("dat_o model", 32'(bus_if.dat_o), 32'(exp_q[0].mdl));
            if (exp_q[0].has_lit) check("dat_o literal", 32'(bus_if.dat_o), 32'(exp_q[0].lit));
            void'(exp_q.pop_front());
         end else begin
            check("val_o idle", 32'(bus_if.val_o), 32'd0);
         end
         check("done_o", 32'(bus_if.done_o), 32'(cyc == done_due));
      end
   end

   task automatic run_image(input int w, input int h, input int gap, input bit exp_err,
                            input bit use_lit);
      compute_model(w, h);
      @(negedge clk);
      bus_if.cfg_w_i = 5'(w);
      bus_if.cfg_h_i = 8'(h);
      bus_if.start_i = 1'b1;
      @(negedge clk);
      bus_if.start_i = 1'b0;
      check("err_o cleared by start", 32'(bus_if.err_o), 32'd0);
      for (int r = 0; r < h; r++) begin
         bus_if.val_i = 1'b1;
         bus_if.dat_i = {16'h0, typ_in[r]};
         @(negedge clk);
         bus_if.val_i = 1'b0;
         repeat (gap) @(negedge clk);
         for (int c = 0; c < w; c++) begin
            exp_t e;
            e.due     = cyc + 2;
            e.mdl     = rec[r*w+c];
            e.lit     = lit_in[r*w+c];
            e.has_lit = use_lit;
            exp_q.push_back(e);
            if (r == h - 1 && c == w - 1) done_due = cyc + 3;
            bus_if.val_i = 1'b1;
            bus_if.dat_i = pix_in[r*w+c];
            @(negedge clk);
            bus_if.val_i = 1'b0;
            repeat (gap) @(negedge clk);
         end
      end
      for (int k = 0; k < 20; k++) begin
         if (exp_q.size() == 0 && cyc >= done_due) break;
         @(negedge clk);
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL output timeout: %0d pixels missing, required 0", exp_q.size());
         exp_q.delete();
      end
      check("err_o after image", 32'(bus_if.err_o), 32'(exp_err));
   endtask

   initial begin
      bus_if.cfg_w_i = '0;
      bus_if.cfg_h_i = '0;
      bus_if.start_i = 1'b0;
      bus_if.val_i   = 1'b0;
      bus_if.dat_i   = '0;
      repeat (3) @(negedge clk);
      check("reset val_o", 32'(bus_if.val_o), 32'd0);
      check("reset dat_o", 32'(bus_if.dat_o), 32'd0);
      check("reset done_o", 32'(bus_if.done_o), 32'd0);
      check("reset err_o", 32'(bus_if.err_o), 32'd0);
      rstn = 1'b1;
      @(negedge clk);
      chk_en = 1'b1;

      // None, w=2 h=1
      typ_in[0] = 8'h00; pix_in[0] = 24'h102030; pix_in[1] = 24'h405060;
      lit_in[0] = 24'h102030; lit_in[1] = 24'h405060;
      run_image(2, 1, 0, 1'b0, 1'b1);

      // Sub with lane wrap, gapped beats
      typ_in[0] = 8'h01; pix_in[0] = 24'hFF0101; pix_in[1] = 24'h020101;
      lit_in[0] = 24'hFF0101; lit_in[1] = 24'h010202;
      run_image(2, 1, 1, 1'b0, 1'b1);

      // w=1 back-to-back Up: write/read same column collide
      typ_in[0] = 8'h00; typ_in[1] = 8'h02;
      pix_in[0] = 24'h0A0B0C; pix_in[1] = 24'h010101;
      lit_in[0] = 24'h0A0B0C; lit_in[1] = 24'h0B0C0D;
      run_image(1, 2, 0, 1'b0, 1'b1);

      // Avg
      typ_in[0] = 8'h00; typ_in[1] = 8'h03;
      pix_in[0] = 24'h646464; pix_in[1] = 24'h000000; pix_in[2] = 24'h0; pix_in[3] = 24'h0;
      lit_in[0] = 24'h646464; lit_in[1] = 24'h000000;
      lit_in[2] = 24'h323232; lit_in[3] = 24'h191919;
      run_image(2, 2, 2, 1'b0, 1'b1);

      // Illegal type 0x07 decodes as None and sets err_o
      typ_in[0] = 8'h07; pix_in[0] = 24'h112233; lit_in[0] = 24'h112233;
      run_image(1, 1, 0, 1'b1, 1'b1);
      repeat (3) @(negedge clk);
      check("err_o sticky", 32'(bus_if.err_o), 32'd1);

      // Abandon an image with reset while a pixel is in flight
      chk_en = 1'b0;
      bus_if.cfg_w_i = 5'd2;
      bus_if.cfg_h_i = 8'd1;
      bus_if.start_i = 1'b1;
      @(negedge clk);
      bus_if.start_i = 1'b0;
      bus_if.val_i   = 1'b1;
      bus_if.dat_i   = 24'h000009;
      @(negedge clk);
      check("err_o on bad type", 32'(bus_if.err_o), 32'd1);
      bus_if.dat_i = 24'h123456;
      @(negedge clk);
      bus_if.val_i = 1'b0;
      rstn = 1'b0;
      @(negedge clk);
      check("mid-reset val_o", 32'(bus_if.val_o), 32'd0);
      check("mid-reset dat_o", 32'(bus_if.dat_o), 32'd0);
      check("mid-reset done_o", 32'(bus_if.done_o), 32'd0);
      check("mid-reset err_o", 32'(bus_if.err_o), 32'd0);
      rstn = 1'b1;
      @(negedge clk);
      chk_en = 1'b1;

      // Paeth after reset
      typ_in[0] = 8'h00; typ_in[1] = 8'h04;
      pix_in[0] = 24'h0A0A0A; pix_in[1] = 24'h141414;
      pix_in[2] = 24'h010101; pix_in[3] = 24'h010101;
      lit_in[0] = 24'h0A0A0A; lit_in[1] = 24'h141414;
      lit_in[2] = 24'h0B0B0B; lit_in[3] = 24'h151515;
      run_image(2, 2, 0, 1'b0, 1'b1);

      // Larger mixed image against the model only
      typ_in[0] = 8'h04; typ_in[1] = 8'h03; typ_in[2] = 8'h04; typ_in[3] = 8'h00;
      for (int i = 0; i < 16; i++) pix_in[i] = 24'($urandom);
      run_image(5, 3, 0, 1'b0, 1'b0);

      typ_in[0] = 8'h02; typ_in[1] = 8'h01; typ_in[2] = 8'h04;
      for (int i = 0; i < 16; i++) pix_in[i] = 24'($urandom);
      run_image(4, 3, 1, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/unfilter.md
UNFILTER -- requirements
Module: unfilter

Interface
REQ-001 SHALL expose parameter SIZE_W_MAX, default `SIZE_W_MAX, maximum row width in pixels (line-buffer depth).
REQ-002 SHALL expose parameter DATA_PXL_WD, default `DATA_PXL_WD (24), pixel width in bits, multiple of 8.
REQ-003 SHALL have port clk  in  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port rstn  in  1  reset, synchronous and active-low.
REQ-005 SHALL have port cfg_w_i  in  `SIZE_W_WD  image width in pixels, 1..SIZE_W_MAX, sampled at start_i.
REQ-006 SHALL have port cfg_h_i  in  `SIZE_H_WD  image height in rows, >=1, sampled at start_i.
REQ-007 SHALL have port start_i  in  1  one-cycle pulse that starts an image.
REQ-008 SHALL have port done_o  out  1  one-cycle pulse when the last pixel has been output.
REQ-009 SHALL have port val_i  in  1  input beat valid; no backpressure.
REQ-010 SHALL have port dat_i  in  DATA_PXL_WD  filter-type byte in [7:0] on a row's first beat, else filtered pixel.
REQ-011 SHALL have port val_o  out  1  reconstructed pixel valid.
REQ-012 SHALL have port dat_o  out  DATA_PXL_WD  reconstructed pixel.
REQ-013 SHALL have port err_o  out  1  sticky flag: an illegal filter type was received.

Function
REQ-014 SHALL implement FSM IDLE -> TYPE (on start_i) -> PIX (on type beat) -> TYPE after cfg_w_i pixels, or DONE after the last row -> IDLE.
REQ-015 SHALL ignore val_i in IDLE and DONE, and SHALL ignore start_i outside IDLE.
REQ-016 SHALL treat each row as 1 type beat followed by cfg_w_i pixel beats; gaps between beats are allowed.
REQ-017 SHALL latch type = dat_i[2:0] on the type beat; values 5..7 (or [7:3]!=0) SHALL decode as None and set err_o.
REQ-018 SHALL operate per byte lane, modulo 256: a = left reconstructed pixel, b = above, c = above-left.
REQ-019 SHALL use a=c=0 in column 0 and b=c=0 in row 0.
REQ-020 SHALL compute None: x; Sub: x+a; Up: x+b; Avg: x+floor((a+b)/2) using a 9-bit sum; Paeth: x+pred.
REQ-021 SHALL compute the Paeth predictor from p=a+b-c (signed 10-bit) and pa=|p-a|, pb=|p-b|, pc=|p-c|, breaking ties in the order a, then b, then c.
REQ-022 SHALL assert val_o with dat_o exactly 2 cycles after the pixel's val_i, with one output per pixel beat and none for type beats.
REQ-023 SHALL write each output pixel into the line buffer at its column, and SHALL read b for column x in the stage-1 cycle.
REQ-024 SHALL forward the in-flight write data as b when a read and a write address the same column in the same cycle (needed for cfg_w_i=1).
REQ-025 SHALL take c from the b value registered for the previous column, zeroed at column 0.
REQ-026 SHALL pulse done_o in the cycle after the last val_o, then return to IDLE.
REQ-027 SHALL clear err_o on start_i.

Reset
REQ-028 SHALL, while rstn=0 at a clock edge, set the FSM to IDLE, clear counters and pipeline valids, and drive val_o=0, dat_o=0, done_o=0, err_o=0.
REQ-029 SHALL abandon any image in progress on reset; line-buffer contents need not be cleared because row 0 forces b=c=0.

Structure
REQ-030 SHALL take `SIZE_W_WD, `SIZE_H_WD, `SIZE_W_MAX, `DATA_PXL_WD and the filter-type codes (NONE=0, SUB=1, UP=2, AVG=3, PAETH=4) from the shared define file.
REQ-031 SHALL instantiate one sub-module, unfilter_linebuf: a SIZE_W_MAX x DATA_PXL_WD single-write / single-read RAM with 1-cycle synchronous read; forwarding stays in unfilter.

Verification (DATA_PXL_WD=24)
REQ-032 SHALL test w=2, h=1, type 0, pixels 0x102030, 0x405060 -> dat_o 0x102030, 0x405060, each 2 cycles after input, then done_o one cycle after the last val_o.
REQ-033 SHALL test w=2, h=1, type 1 (Sub), pixels 0xFF0101, 0x020101 -> 0xFF0101, 0x010202 (lane wrap).
REQ-034 SHALL test w=1, h=2, back-to-back beats: row0 type0 0x0A0B0C; row1 type2 0x010101 -> 0x0B0C0D (forwarding path).
REQ-035 SHALL test w=2, h=2: row0 type0 0x646464, 0x000000; row1 type3 zeros -> 0x323232, 0x191919.
REQ-036 SHALL test w=2, h=2: row0 type0 0x0A0A0A, 0x141414; row1 type4 0x010101, 0x010101 -> 0x0B0B0B, 0x151515.
REQ-037 SHALL test type byte 0x07 -> row decoded as None and err_o=1 until the next start_i; rstn=0 mid-row -> all outputs 0 next cycle, and a new image after reset decodes correctly.
